prog_clock_div: RTL and testbench

PROG_CLOCK_DIV -- requirements
Module: prog_clock_div

---
 rtl/prog_clock_div.sv | 92 +++++++++
 tb/tb_prog_clock_div.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/prog_clock_div.sv
// Multi-channel programmable clock divider with glitch-free divisor updates.
// Define PROG_CLOCK_DIV_SYNC_EN to compile in the sync phase-align feature.
module prog_clock_div #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         cfg_we,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [DIV_W-1:0]                             cfg_div,
    input  logic                                         sync,
    output logic [NUM_CH-1:0]                            div_clk,
    output logic [NUM_CH-1:0]                            tick,
    output logic [NUM_CH-1:0]                            pending
);

    localparam int               CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [DIV_W-1:0] DEF_A = DIV_W'(DEFAULT_DIV);

    logic ch_ok;
    logic sync_hit;

    // Non-power-of-two channel counts leave index codes that must be dropped.
    assign ch_ok = (32'(cfg_ch) < 32'(NUM_CH));

`ifdef PROG_CLOCK_DIV_SYNC_EN
    assign sync_hit = sync;
`else
    logic unused_sync;
    assign sync_hit    = 1'b0;
    assign unused_sync = sync;
`endif

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [DIV_W-1:0] act_q;
        logic [DIV_W-1:0] pnd_q;
        logic [DIV_W-1:0] cnt_q;
        logic [DIV_W-1:0] half;
        logic             pend_q;
        logic             we_hit;
        logic             running;
        logic             wrap;

        assign we_hit  = cfg_we && ch_ok && (cfg_ch == CH_W'(ch));
        assign running = (act_q != '0);
        assign wrap    = running && (cnt_q >= act_q - DIV_W'(1));
        assign half    = act_q >> 1;

        // Outputs decode registered state only.
        assign div_clk[ch] = running && (cnt_q >= half);
        assign tick[ch]    = running && (cnt_q == half);
        assign pending[ch] = pend_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                act_q  <= DEF_A;
                pnd_q  <= '0;
                cnt_q  <= '0;
                pend_q <= 1'b0;
            end else begin
                if (we_hit) pnd_q <= cfg_div;

                if (sync_hit || wrap) begin
                    // Period boundary: a write landing here bypasses the pending slot.
                    cnt_q <= '0;
                    if (we_hit) begin
                        act_q  <= cfg_div;
                        pend_q <= 1'b0;
                    end else if (pend_q) begin
                        act_q  <= pnd_q;
                        pend_q <= 1'b0;
                    end
                end else if (!running) begin
                    // Stopped: a fresh write wins, otherwise load what is pending.
                    cnt_q <= '0;
                    if (we_hit) begin
                        pend_q <= 1'b1;
                    end else if (pend_q) begin
                        act_q  <= pnd_q;
                        pend_q <= 1'b0;
                    end
                end else begin
                    cnt_q <= cnt_q + DIV_W'(1);
                    if (we_hit) pend_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_clock_div.sv
// Directed bench for prog_clock_div: reset, divisor updates, stop/resume, sync.
// Vectors are {ch3,ch2,ch1,ch0}; each step checks state at the falling edge.
module tb_prog_clock_div;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic       sync;
    logic [3:0] div_clk;
    logic [3:0] tick;
    logic [3:0] pending;

    logic [1:0] cfg_ch_b;
    logic [2:0] div_b;
    logic [2:0] tick_b;
    logic [2:0] pend_b;

    int n_asrt = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    prog_clock_div #(.NUM_CH(4), .DIV_W(8), .DEFAULT_DIV(2)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .sync(sync), .div_clk(div_clk), .tick(tick), .pending(pending)
    );

    // Three channels leave index 3 out of range; divisor 1 at reset.
    prog_clock_div #(.NUM_CH(3), .DIV_W(8), .DEFAULT_DIV(1)) dut_b (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch_b), .cfg_div(cfg_div),
        .sync(sync), .div_clk(div_b), .tick(tick_b), .pending(pend_b)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] ed, input logic [3:0] et,
                        input logic [3:0] ep);
        @(negedge clk);
        chk({tag, ".div"}, div_clk, ed);
        chk({tag, ".tick"}, tick, et);
        chk({tag, ".pend"}, pending, ep);
    endtask

    task automatic chk_b(input string tag);
        chk({tag, ".b_div"}, {1'b0, div_b}, 4'b0111);
        chk({tag, ".b_tick"}, {1'b0, tick_b}, 4'b0111);
        chk({tag, ".b_pend"}, {1'b0, pend_b}, 4'b0000);
    endtask

    initial begin
        rst      = 1'b1;
        cfg_we   = 1'b0;
        cfg_ch   = 2'd0;
        cfg_div  = 8'd0;
        sync     = 1'b0;
        cfg_ch_b = 2'd3;
        @(negedge clk);
        step("rst", 4'b0000, 4'b0000, 4'b0000);
        chk_b("rst");
        rst = 1'b0;

        // Default divide-by-2 on every channel
        for (int r = 1; r <= 4; r++)
            step($sformatf("div2_r%0d", r), (r % 2) ? 4'hF : 4'h0, (r % 2) ? 4'hF : 4'h0, 4'h0);

        // ch1 -> 5 mid-period
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd5;
        step("w5_r5", 4'b1111, 4'b1111, 4'b0010);
        cfg_we = 1'b0;
        step("w5_r6", 4'b0000, 4'b0000, 4'b0000);
        step("w5_r7", 4'b1101, 4'b1101, 4'b0000);
        step("w5_r8", 4'b0010, 4'b0010, 4'b0000);
        step("w5_r9", 4'b1111, 4'b1101, 4'b0000);
        step("w5_r10", 4'b0010, 4'b0000, 4'b0000);
        step("w5_r11", 4'b1101, 4'b1101, 4'b0000);
        step("w5_r12", 4'b0000, 4'b0000, 4'b0000);
        step("w5_r13", 4'b1111, 4'b1111, 4'b0000);
        step("w5_r14", 4'b0010, 4'b0000, 4'b0000);

        // ch2 -> 0 (stop at wrap), then -> 3 (resume)
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd0;
        step("stop_r15", 4'b1111, 4'b1101, 4'b0100);
        cfg_we = 1'b0;
        step("stop_r16", 4'b0000, 4'b0000, 4'b0000);
        step("stop_r17", 4'b1001, 4'b1001, 4'b0000);
        step("stop_r18", 4'b0010, 4'b0010, 4'b0000);
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd3;
        step("res_r19", 4'b1011, 4'b1001, 4'b0100);
        cfg_we = 1'b0;
        step("res_r20", 4'b0010, 4'b0000, 4'b0000);
        step("res_r21", 4'b1101, 4'b1101, 4'b0000);
        step("res_r22", 4'b0100, 4'b0000, 4'b0000);
        step("res_r23", 4'b1011, 4'b1011, 4'b0000);
        step("res_r24", 4'b0110, 4'b0100, 4'b0000);

        // ch0: 7 then 4 before the period ends; the second lands on the wrap
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd7;
        step("ow_r25", 4'b1111, 4'b1001, 4'b0001);
        cfg_div = 8'd4;
        step("ow_r26", 4'b0000, 4'b0000, 4'b0000);
        cfg_we = 1'b0;
        chk_b("ow_r26");
        step("ow_r27", 4'b1100, 4'b1100, 4'b0000);
        step("ow_r28", 4'b0111, 4'b0011, 4'b0000);
        step("ow_r29", 4'b1011, 4'b1000, 4'b0000);
        step("ow_r30", 4'b0110, 4'b0100, 4'b0000);
        step("ow_r31", 4'b1100, 4'b1000, 4'b0000);
        step("ow_r32", 4'b0001, 4'b0001, 4'b0000);

        // Divisors now 4,5,3,2 on ch0..ch3; pulse sync
        sync = 1'b1;
`ifdef PROG_CLOCK_DIV_SYNC_EN
        step("sync_r33", 4'b0000, 4'b0000, 4'b0000);
        sync = 1'b0;
        step("sync_r34", 4'b1100, 4'b1100, 4'b0000);
        step("sync_r35", 4'b0111, 4'b0011, 4'b0000);
`else
        step("nosync_r33", 4'b1111, 4'b1110, 4'b0000);
        sync = 1'b0;
        step("nosync_r34", 4'b0110, 4'b0000, 4'b0000);
        step("nosync_r35", 4'b1010, 4'b1000, 4'b0000);
`endif

        // Reset mid-period overrides a simultaneous write
        rst = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd7;
        step("rst_r36", 4'b0000, 4'b0000, 4'b0000);
        rst = 1'b0; cfg_we = 1'b0;
        step("rst_r37", 4'b1111, 4'b1111, 4'b0000);
        chk_b("rst_r37");
        step("rst_r38", 4'b0000, 4'b0000, 4'b0000);
        step("rst_r39", 4'b1111, 4'b1111, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
